// File: rtl/slot_pkg.sv
// slot_pkg: shared game state enum, reel types and LFSR step for the slot game
package slot_pkg;
  localparam int NUM_REELS = 3;
  localparam int NUM_SYMBOLS = 4;
  typedef enum logic [1:0] {IDLE, SPIN, EVAL, WIN_SHOW} game_state_t;
  typedef logic [$clog2(NUM_SYMBOLS)-1:0] reel_pos_t;
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered rising-edge pulse of a level input; ports clk, rst_n (async low), din, rise
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic prev_q, prev_d, rise_q, rise_d;
  always_comb begin
    prev_d = din;
    rise_d = din & ~prev_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  assign rise = rise_q;
endmodule

// File: rtl/slot_game_ctrl.sv
// slot_game_ctrl: slot game sequencer; in clk, rst_n (async low), btn_up/down/spin, frame_tick; out money, bet, reel_pos, spinning, stop, win
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int MONEY_INIT  = 100,
  parameter int MONEY_MAX   = 999,
  parameter int BET_MAX     = 9,
  parameter int PAYOUT      = 10,
  parameter int SPIN_FRAMES = 60,
  parameter int STAGGER     = 30,
  parameter int WIN_FRAMES  = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_spin,
  input  logic       frame_tick,
  output logic [9:0] money,
  output logic [3:0] bet,
  output logic [5:0] reel_pos,
  output logic [2:0] spinning,
  output logic       stop,
  output logic       win
);
  localparam int CW = $clog2(SPIN_FRAMES + 2 * STAGGER + 1);
  game_state_t state_q, state_d;
  logic [9:0] money_q, money_d;
  logic [3:0] bet_q, bet_d;
  logic [5:0] pos_q, pos_d;
  logic [2:0] spin_q, spin_d;
  logic stop_q, stop_d, win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic [7:0] lfsr_q, lfsr_d;
  logic [10:0] sum;
  logic up_e, dn_e, spin_e;
  edge_detect u_up   (.clk(clk), .rst_n(rst_n), .din(btn_up),   .rise(up_e));
  edge_detect u_down (.clk(clk), .rst_n(rst_n), .din(btn_down), .rise(dn_e));
  edge_detect u_spin (.clk(clk), .rst_n(rst_n), .din(btn_spin), .rise(spin_e));
  assign cnt_nx = cnt_q + 1'b1;
  assign sum = 11'(money_q) + 11'(bet_q) * 11'(PAYOUT);
  always_comb begin
    state_d = state_q;
    money_d = money_q;
    bet_d = bet_q;
    pos_d = pos_q;
    spin_d = spin_q;
    win_d = win_q;
    cnt_d = cnt_q;
    lfsr_d = lfsr_step(lfsr_q);
    case (state_q)
      IDLE:
        if (spin_e) begin
          if ({6'd0, bet_q} <= money_q) begin
            money_d = money_q - 10'(bet_q);
            pos_d = lfsr_q[5:0];
            spin_d = 3'b111;
            cnt_d = '0;
            state_d = SPIN;
          end
        end else
          bet_d = (up_e & ~dn_e & bet_q != 4'(BET_MAX)) ? bet_q + 4'd1 :
                  (dn_e & ~up_e & bet_q != 4'd1) ? bet_q - 4'd1 : bet_q;
      SPIN:
        if (spin_q == 3'b000)
          state_d = EVAL;
        else if (frame_tick) begin
          cnt_d = cnt_nx;
          for (int i = 0; i < NUM_REELS; i++)
            if (spin_q[i]) begin
              if (cnt_nx == CW'(SPIN_FRAMES + i * STAGGER))
                spin_d[i] = 1'b0;
              else
                pos_d[2*i +: 2] = pos_q[2*i +: 2] + reel_pos_t'(1);
            end
        end
      EVAL:
        if (pos_q[1:0] == pos_q[3:2] && pos_q[3:2] == pos_q[5:4]) begin
          money_d = sum > 11'(MONEY_MAX) ? 10'(MONEY_MAX) : sum[9:0];
          win_d = 1'b1;
          cnt_d = '0;
          state_d = WIN_SHOW;
        end else
          state_d = IDLE;
      WIN_SHOW:
        if (frame_tick) begin
          cnt_d = cnt_nx;
          if (cnt_nx == CW'(WIN_FRAMES)) begin
            win_d = 1'b0;
            state_d = IDLE;
          end
        end
      default: state_d = IDLE;
    endcase
    stop_d = ~|spin_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      money_q <= 10'(MONEY_INIT);
      bet_q <= 4'd1;
      pos_q <= '0;
      spin_q <= '0;
      stop_q <= 1'b1;
      win_q <= 1'b0;
      cnt_q <= '0;
      lfsr_q <= 8'hA5;
    end else begin
      state_q <= state_d;
      money_q <= money_d;
      bet_q <= bet_d;
      pos_q <= pos_d;
      spin_q <= spin_d;
      stop_q <= stop_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  assign money = money_q;
  assign bet = bet_q;
  assign reel_pos = pos_q;
  assign spinning = spin_q;
  assign stop = stop_q;
  assign win = win_q;
endmodule

// File: tb/tb_slot_game_ctrl.sv
// tb_slot_game_ctrl: randomized self-checking bench against a behavioural game model
module tb_slot_game_ctrl;
  localparam int MONEY_INIT = 100, MONEY_MAX = 999, BET_MAX = 9, PAYOUT = 10;
  localparam int SPIN_FRAMES = 60, STAGGER = 30, WIN_FRAMES = 120;
  logic clk = 0, rst_n = 0, btn_up = 0, btn_down = 0, btn_spin = 0, frame_tick = 0;
  logic [9:0] money;
  logic [3:0] bet;
  logic [5:0] reel_pos;
  logic [2:0] spinning;
  logic stop, win;
  int vectors = 0, miscompares = 0;
  int m_money, m_bet, m_phase, m_frames;
  int m_pos[3];
  logic [2:0] m_spin, m_prev, m_edge, m_ed;
  logic m_win;
  logic [7:0] m_lfsr, used;
  always #5 clk = ~clk;
  slot_game_ctrl #(
    .MONEY_INIT(MONEY_INIT), .MONEY_MAX(MONEY_MAX), .BET_MAX(BET_MAX), .PAYOUT(PAYOUT),
    .SPIN_FRAMES(SPIN_FRAMES), .STAGGER(STAGGER), .WIN_FRAMES(WIN_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_spin(btn_spin),
    .frame_tick(frame_tick), .money(money), .bet(bet), .reel_pos(reel_pos),
    .spinning(spinning), .stop(stop), .win(win)
  );
  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction
  function automatic bit wins(input logic [7:0] v);
    int f[3];
    for (int i = 0; i < 3; i++) f[i] = (int'(v[2*i +: 2]) + SPIN_FRAMES + i * STAGGER - 1) % 4;
    return f[0] == f[1] && f[1] == f[2];
  endfunction
  function automatic int exp_pos();
    return m_pos[2] * 16 + m_pos[1] * 4 + m_pos[0];
  endfunction
  task automatic model_reset();
    m_money = MONEY_INIT; m_bet = 1; m_pos = '{0, 0, 0}; m_spin = 0; m_win = 0;
    m_phase = 0; m_frames = 0; m_lfsr = 8'hA5; m_prev = 0; m_edge = 0;
  endtask
  task automatic advance();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_ed = m_edge;
    m_edge = {btn_spin, btn_down, btn_up} & ~m_prev;
    m_prev = {btn_spin, btn_down, btn_up};
    if (m_phase == 0) begin
      if (m_ed[2]) begin
        if (m_bet <= m_money) begin
          m_money -= m_bet;
          for (int i = 0; i < 3; i++) m_pos[i] = int'(m_lfsr[2*i +: 2]);
          m_spin = 3'b111; m_frames = 0; m_phase = 1;
        end
      end else if (m_ed[1:0] == 2'b01) m_bet = m_bet < BET_MAX ? m_bet + 1 : m_bet;
      else if (m_ed[1:0] == 2'b10) m_bet = m_bet > 1 ? m_bet - 1 : 1;
    end else if (m_phase == 1) begin
      if (m_spin == 0) m_phase = 2;
      else if (frame_tick) begin
        m_frames++;
        for (int i = 0; i < 3; i++)
          if (m_spin[i]) begin
            if (m_frames == SPIN_FRAMES + i * STAGGER) m_spin[i] = 1'b0;
            else m_pos[i] = (m_pos[i] + 1) % 4;
          end
      end
    end else if (m_phase == 2) begin
      if (m_pos[0] == m_pos[1] && m_pos[1] == m_pos[2]) begin
        m_money = m_money + m_bet * PAYOUT > MONEY_MAX ? MONEY_MAX : m_money + m_bet * PAYOUT;
        m_win = 1; m_frames = 0; m_phase = 3;
      end else m_phase = 0;
    end else if (frame_tick) begin
      m_frames++;
      if (m_frames == WIN_FRAMES) begin
        m_win = 0; m_phase = 0;
      end
    end
    m_lfsr = nxt(m_lfsr);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask
  task automatic timeout(input string name);
    miscompares++;
    $display("FAIL timeout %s at %0t", name, $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "bound expired");
  endtask
  task automatic step(input bit noise);
    advance();
    @(negedge clk);
    if (rst_n) begin
      chk("money", 32'(money), 32'(m_money));
      chk("bet", 32'(bet), 32'(m_bet));
      chk("reel_pos", 32'(reel_pos), 32'(exp_pos()));
      chk("spinning", 32'(spinning), 32'(m_spin));
      chk("stop", 32'(stop), 32'(m_spin == 0));
      chk("win", 32'(win), 32'(m_win));
    end
    frame_tick = 1'($urandom_range(0, 1));
    if (noise) {btn_spin, btn_down, btn_up} = (m_phase == 1 && m_spin != 0) ? 3'($urandom) : 3'b000;
  endtask
  task automatic do_reset();
    {btn_spin, btn_down, btn_up} = 3'b000;
    rst_n = 0;
    step(0); step(0);
    rst_n = 1;
    step(0);
  endtask
  task automatic press(input int k);
    {btn_spin, btn_down, btn_up} = 3'(1 << k);
    step(0);
    {btn_spin, btn_down, btn_up} = 3'b000;
    step(0); step(0);
  endtask
  task automatic set_bet(input int target);
    for (int n = 0; n < 20 && m_bet < target; n++) press(0);
    for (int n = 0; n < 20 && m_bet > target; n++) press(1);
    if (m_bet != target) timeout("set_bet");
  endtask
  task automatic spin_go(input bit want);
    int n = 0;
    while (wins(nxt(m_lfsr)) != want && n < 600) begin
      step(0);
      n++;
    end
    if (n == 600) timeout("spin_go");
    used = nxt(m_lfsr);
    btn_spin = 1;
    step(0);
    btn_spin = 0;
    step(0);
  endtask
  task automatic wait_idle(input bit noise);
    int n = 0;
    while (m_phase != 0 && n < 3000) begin
      step(noise);
      n++;
    end
    if (n == 3000) timeout("wait_idle");
    {btn_spin, btn_down, btn_up} = 3'b000;
    step(0);
  endtask
  initial begin
    int n;
    do_reset();
    chk("rst_money", 32'(money), 100);
    chk("rst_bet", 32'(bet), 1);
    chk("rst_reel", 32'(reel_pos), 0);
    chk("rst_spinning", 32'(spinning), 0);
    chk("rst_stop", 32'(stop), 1);
    chk("rst_win", 32'(win), 0);
    repeat (12) press(0);
    chk("bet_hi_sat", 32'(bet), 9);
    repeat (12) press(1);
    chk("bet_lo_sat", 32'(bet), 1);
    chk("money_unchanged", 32'(money), 100);
    repeat (4) press(0);
    spin_go(0);
    chk("spin_deduct", 32'(money), 95);
    chk("spin_reel_load", 32'(reel_pos), 32'(used[5:0]));
    chk("spin_all", 32'(spinning), 7);
    wait_idle(1);
    chk("bet_kept_after_noise", 32'(bet), 5);
    chk("stop_after", 32'(stop), 1);
    chk("lose_money", 32'(money), 95);
    do_reset();
    set_bet(9);
    spin_go(1);
    chk("win_deduct", 32'(money), 91);
    n = 0;
    while (m_phase != 3 && n < 1000) begin
      step(1);
      n++;
    end
    if (n == 1000) timeout("win_show");
    chk("win_flag", 32'(win), 1);
    chk("win_money", 32'(money), 181);
    wait_idle(1);
    chk("win_cleared", 32'(win), 0);
    n = 0;
    while (m_money > 3 && n < 60) begin
      set_bet(m_money - 3 > 9 ? 9 : m_money - 3);
      spin_go(0);
      wait_idle(1);
      n++;
    end
    chk("drained", 32'(money), 3);
    set_bet(5);
    spin_go(0);
    step(0);
    chk("refused_money", 32'(money), 3);
    chk("refused_spinning", 32'(spinning), 0);
    chk("refused_stop", 32'(stop), 1);
    press(0);
    chk("refused_still_idle", 32'(bet), 6);
    n = 0;
    while (m_money < MONEY_MAX && n < 40) begin
      set_bet(m_money < 9 ? m_money : 9);
      spin_go(1);
      wait_idle(1);
      n++;
    end
    chk("money_saturated", 32'(money), 999);
    set_bet(4);
    spin_go(0);
    n = 0;
    while (!(m_phase == 1 && m_frames == 45) && n < 1000) begin
      step(1);
      n++;
    end
    if (n == 1000) timeout("tick45");
    {btn_spin, btn_down, btn_up} = 3'b000;
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_money", 32'(money), 100);
    chk("mid_rst_bet", 32'(bet), 1);
    chk("mid_rst_reel", 32'(reel_pos), 0);
    chk("mid_rst_spinning", 32'(spinning), 0);
    chk("mid_rst_stop", 32'(stop), 1);
    chk("mid_rst_win", 32'(win), 0);
    step(0);
    rst_n = 1;
    step(0); step(0);
    chk("post_rst_bet", 32'(bet), 1);
    finish_run();
  end
endmodule
